// File: rtl/codec_write_buffer.sv
// codec_write_buffer
//   Output stage between the stereo FIR pair and the audio CODEC write port.
//   Each filtered L/R pair flagged by in_valid_i is attenuated by an arithmetic
//   right shift and queued in a small FIFO. One pair is written per CODEC
//   write_ready window as a single-cycle strobe with left-justified data.
//   Overrun (drop on full) and underrun (empty window) events are counted.
//
// Ports
//   ck_i                 system clock
//   rst_ni               asynchronous active-low reset
//   in_left_i/in_right_i filtered samples, two's complement
//   in_valid_i           one-cycle pulse, both samples valid
//   att_i                attenuation shift 0..7, sampled at push
//   write_ready_i        CODEC can accept a pair
//   write_o              one-cycle write strobe
//   writedata_left_o/writedata_right_o  left-justified CODEC data
//   level_o              FIFO occupancy
//   overrun_cnt_o        dropped pairs, saturating
//   underrun_cnt_o       empty ready windows, saturating
module codec_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 24
) (
    input  logic                     ck_i,
    input  logic                     rst_ni,
    input  logic [IN_W-1:0]          in_left_i,
    input  logic [IN_W-1:0]          in_right_i,
    input  logic                     in_valid_i,
    input  logic [2:0]               att_i,
    input  logic                     write_ready_i,
    output logic                     write_o,
    output logic [OUT_W-1:0]         writedata_left_o,
    output logic [OUT_W-1:0]         writedata_right_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [7:0]               overrun_cnt_o,
    output logic [7:0]               underrun_cnt_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned PadW = OUT_W - IN_W;

    typedef enum logic {StIdle, StWaitLow} state_e;

    state_e                  state_q, state_d;
    logic [2*IN_W-1:0]       mem_q [DEPTH];
    logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]         level_q, level_d;
    logic [7:0]              ovr_q, ovr_d;
    logic [7:0]              und_q, und_d;
    logic                    write_q;
    logic [OUT_W-1:0]        wd_left_q, wd_right_q;

    logic                    pop, push, full, underrun_inc, overrun_inc;
    logic signed [IN_W-1:0]  left_sh, right_sh;
    logic [2*IN_W-1:0]       head;

    assign left_sh  = $signed(in_left_i) >>> att_i;
    assign right_sh = $signed(in_right_i) >>> att_i;
    assign head     = mem_q[rd_ptr_q];
    assign full     = (level_q == LvlW'(DEPTH));

    // Window FSM: at most one pop (or one underrun) per write_ready assertion.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        underrun_inc = 1'b0;
        case (state_q)
            StIdle: begin
                if (write_ready_i) begin
                    state_d = StWaitLow;
                    if (level_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        underrun_inc = 1'b1;
                    end
                end
            end
            StWaitLow: begin
                if (!write_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A same-cycle pop frees the slot, so a push into a full FIFO is accepted.
    always_comb begin
        push        = in_valid_i && (!full || pop);
        overrun_inc = in_valid_i && full && !pop;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end

        ovr_d = ovr_q;
        if (overrun_inc && (ovr_q != 8'hff)) begin
            ovr_d = ovr_q + 8'd1;
        end

        und_d = und_q;
        if (underrun_inc && (und_q != 8'hff)) begin
            und_d = und_q + 8'd1;
        end
    end

    always_ff @(posedge ck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovr_q      <= '0;
            und_q      <= '0;
            write_q    <= 1'b0;
            wd_left_q  <= '0;
            wd_right_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            ovr_q   <= ovr_d;
            und_q   <= und_d;
            write_q <= pop;
            if (push) begin
                mem_q[wr_ptr_q] <= {left_sh, right_sh};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                wd_left_q  <= OUT_W'(head[2*IN_W-1:IN_W]) << PadW;
                wd_right_q <= OUT_W'(head[IN_W-1:0]) << PadW;
            end
        end
    end

    assign write_o           = write_q;
    assign writedata_left_o  = wd_left_q;
    assign writedata_right_o = wd_right_q;
    assign level_o           = level_q;
    assign overrun_cnt_o     = ovr_q;
    assign underrun_cnt_o    = und_q;

endmodule

// File: tb/tb_codec_write_buffer.sv
module tb_codec_write_buffer;

    localparam int DEPTH = 4;

    logic        ck;
    logic        rst_n;
    logic [15:0] in_left, in_right;
    logic        in_valid;
    logic [2:0]  att;
    logic        write_ready;
    logic        write;
    logic [23:0] wd_left, wd_right;
    logic [2:0]  level;
    logic [7:0]  ovr_cnt, und_cnt;

    codec_write_buffer #(
        .DEPTH (DEPTH),
        .IN_W  (16),
        .OUT_W (24)
    ) dut (
        .ck_i              (ck),
        .rst_ni            (rst_n),
        .in_left_i         (in_left),
        .in_right_i        (in_right),
        .in_valid_i        (in_valid),
        .att_i             (att),
        .write_ready_i     (write_ready),
        .write_o           (write),
        .writedata_left_o  (wd_left),
        .writedata_right_o (wd_right),
        .level_o           (level),
        .overrun_cnt_o     (ovr_cnt),
        .underrun_cnt_o    (und_cnt)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int vectors = 0;
    int miscompares = 0;
    int nwrites = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: floor(x / 2^a), i.e. sign-preserving division.
    function automatic logic [15:0] att_shift(input logic [15:0] x, input int a);
        int v, p, q;
        v = int'($signed(x));
        p = 1 << a;
        q = v / p;
        if ((v < 0) && ((v % p) != 0)) q = q - 1;
        return q[15:0];
    endfunction

    // Behavioural model: a queue of pairs, one service per ready window.
    logic [31:0] m_fifo[$];
    logic [31:0] pend[$];
    bit          m_armed;
    bit          m_wr;
    int          m_ov, m_un;
    logic [31:0] m_last;

    always @(posedge ck or negedge rst_n) begin
        int  sz;
        bit  popd;
        logic [31:0] d;
        if (!rst_n) begin
            m_fifo.delete();
            pend.delete();
            m_armed = 1'b1;
            m_wr    = 1'b0;
            m_ov    = 0;
            m_un    = 0;
            m_last  = '0;
        end else begin
            sz   = m_fifo.size();
            popd = 1'b0;
            m_wr = 1'b0;
            if (m_armed && write_ready) begin
                m_armed = 1'b0;
                if (sz > 0) begin
                    d = m_fifo.pop_front();
                    pend.push_back(d);
                    m_last = d;
                    m_wr   = 1'b1;
                    popd   = 1'b1;
                end else if (m_un < 255) begin
                    m_un++;
                end
            end else if (!m_armed && !write_ready) begin
                m_armed = 1'b1;
            end
            if (in_valid) begin
                if (sz < DEPTH || popd) begin
                    m_fifo.push_back({att_shift(in_left, int'(att)),
                                      att_shift(in_right, int'(att))});
                end else if (m_ov < 255) begin
                    m_ov++;
                end
            end
        end
    end

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge ck) begin
        logic [31:0] e;
        if (mon_en) begin
            chk("write_strobe", 48'(write), 48'(m_wr));
            if (write) begin
                nwrites++;
                if (pend.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got write=1 expected no pending pair at %0t",
                             $time);
                end else begin
                    e = pend.pop_front();
                    chk("wd_left", 48'(wd_left), 48'({e[31:16], 8'h00}));
                    chk("wd_right", 48'(wd_right), 48'({e[15:0], 8'h00}));
                end
            end
            chk("hold_left", 48'(wd_left), 48'({m_last[31:16], 8'h00}));
            chk("hold_right", 48'(wd_right), 48'({m_last[15:0], 8'h00}));
            chk("level", 48'(level), 48'(m_fifo.size()));
            chk("overrun_cnt", 48'(ovr_cnt), 48'(m_ov));
            chk("underrun_cnt", 48'(und_cnt), 48'(m_un));
        end
    end

    task automatic cyc(input bit v, input logic [15:0] l, input logic [15:0] r,
                       input logic [2:0] a, input bit wr);
        @(negedge ck);
        #1;
        in_valid    = v;
        in_left     = l;
        in_right    = r;
        att         = a;
        write_ready = wr;
    endtask

    task automatic idle(input bit wr, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 16'h0, 3'd0, wr);
    endtask

    // Sample after the monitor on the current falling edge.
    task automatic settle();
        @(negedge ck);
        #2;
    endtask

    initial begin
        int w0;
        in_valid = 0; in_left = 0; in_right = 0; att = 0; write_ready = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_write", 48'(write), 48'h0);
        chk("reset_level", 48'(level), 48'h0);
        chk("reset_wd_left", 48'(wd_left), 48'h0);
        mon_en = 1'b1;
        #20 rst_n = 1'b1;

        // Basic push then a single window.
        cyc(1'b1, 16'h1234, 16'hEDCB, 3'd0, 1'b0);
        idle(1'b0, 8);
        settle();
        chk("lvl_one", 48'(level), 48'd1);
        idle(1'b1, 4);
        idle(1'b0, 2);
        chk("basic_left", 48'(wd_left), 48'h123400);
        chk("basic_right", 48'(wd_right), 48'hEDCB00);

        // Attenuation by 2.
        cyc(1'b1, 16'h8000, 16'h7FFF, 3'd2, 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 3);
        idle(1'b0, 2);
        chk("att_left", 48'(wd_left), 48'hE00000);
        chk("att_right", 48'(wd_right), 48'h1FFF00);

        // Overfill with ready low.
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 16'(16'h0100 + i), 16'(16'hA000 + i), 3'd0, 1'b0);
        end
        idle(1'b0, 1);
        settle();
        chk("full_level", 48'(level), 48'd4);
        chk("full_ovr", 48'(ovr_cnt), 48'd2);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, 2);
            idle(1'b0, 2);
        end

        // Three pairs, one long window, then two short windows.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 16'(16'h3000 + i), 16'(16'hC000 + i), 3'd1, 1'b0);
        end
        idle(1'b0, 1);
        w0 = nwrites;
        idle(1'b1, 20);
        idle(1'b0, 1);
        settle();
        chk("long_window_writes", 48'(nwrites - w0), 48'd1);
        for (int i = 0; i < 2; i++) begin
            idle(1'b1, 3);
            idle(1'b0, 2);
        end
        chk("two_windows_writes", 48'(nwrites - w0), 48'd3);

        // Underrun saturation, no strobes.
        w0 = nwrites;
        for (int i = 0; i < 300; i++) begin
            idle(1'b1, 1);
            idle(1'b0, 1);
        end
        settle();
        chk("underrun_sat", 48'(und_cnt), 48'd255);
        chk("no_write_empty", 48'(nwrites - w0), 48'd0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 16'(16'h5000 + i), 16'(16'h6000 + i), 3'd0, 1'b0);
        end
        w0 = int'(ovr_cnt);
        cyc(1'b1, 16'h7777, 16'h8888, 3'd0, 1'b1);
        settle();
        chk("pushpop_level", 48'(level), 48'd4);
        chk("pushpop_ovr", 48'(ovr_cnt), 48'(w0));
        chk("pushpop_write", 48'(write), 48'd1);
        // Asynchronous reset while waiting for ready to drop.
        #1 rst_n = 1'b0;
        #1;
        chk("arst_write", 48'(write), 48'h0);
        chk("arst_wd_left", 48'(wd_left), 48'h0);
        chk("arst_wd_right", 48'(wd_right), 48'h0);
        chk("arst_level", 48'(level), 48'h0);
        chk("arst_ovr", 48'(ovr_cnt), 48'h0);
        chk("arst_und", 48'(und_cnt), 48'h0);
        cyc(1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
        rst_n = 1'b1;
        idle(1'b1, 2);
        settle();
        chk("post_reset_idle_und", 48'(und_cnt), 48'd1);
        idle(1'b0, 2);

        // Randomised traffic.
        begin
            bit wr;
            wr = 1'b0;
            for (int i = 0; i < 2500; i++) begin
                if ($urandom_range(0, 3) == 0) wr = ~wr;
                cyc(($urandom_range(0, 2) == 0), 16'($urandom), 16'($urandom),
                    3'($urandom_range(0, 7)), wr);
            end
        end
        idle(1'b0, 4);
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/codec_write_buffer.md
Name: codec_write_buffer

Overview:
- Output stage between the stereo FIR pair and the audio CODEC write port.
- Captures each filtered 16-bit L/R sample pair when the filter flags it ready, applies a per-sample attenuation shift, and queues the pair in a small FIFO.
- Issues exactly one single-cycle write strobe per CODEC write_ready window, with 24-bit left-justified data.
- Absorbs filter/CODEC timing skew and counts overrun and underrun events for debug.

Parameters:
DEPTH, 4, FIFO depth in sample pairs; power of two, minimum 2.
IN_W, 16, input sample width, two's complement.
OUT_W, 24, CODEC sample width; must be ≥ IN_W.

Ports:
ck  input  1  system clock (50 MHz domain)
rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately
in_left  input  IN_W  left filtered sample
in_right  input  IN_W  right filtered sample
in_valid  input  1  one-cycle pulse; both samples valid this cycle
att  input  3  attenuation; arithmetic right shift 0..7, sampled at push
write_ready  input  1  CODEC can accept a sample pair
write  output  1  one-cycle write strobe to CODEC
writedata_left  output  OUT_W  left data to CODEC
writedata_right  output  OUT_W  right data to CODEC
level  output  clog2(DEPTH)+1  current FIFO occupancy
overrun_cnt  output  8  samples dropped on full, saturating
underrun_cnt  output  8  ready windows with empty FIFO, saturating

Behaviour:
- Reset (rst=0, async): write=0, writedata_*=0, level=0, both counters 0, FSM=IDLE, FIFO pointers 0. Takes effect mid-transaction; any pending write is discarded.
- Push: in_valid=1 stores {in_left>>>att, in_right>>>att}. The shift is arithmetic (sign-preserving) and uses att in the same cycle.
- Full (level==DEPTH), no pop in the same cycle: the sample is dropped and overrun_cnt increments, saturating at 255.
- Full with a pop in the same cycle: the push is accepted, level is unchanged, and the counter is unchanged.
- Pop happens only when the registered level>0. There is no fall-through: a sample pushed into an empty FIFO is poppable the next cycle at the earliest.
- Pointers wrap modulo DEPTH. level = pushes − pops and never exceeds DEPTH or goes below 0.
- Output format: writedata_x = {stored_sample, (OUT_W−IN_W) zeros}, so the sample occupies bits [OUT_W−1:OUT_W−IN_W].
- FSM, two states:
  - IDLE, write_ready=1, level>0: pop the head. Next cycle, write=1 for exactly one cycle and writedata_* hold the popped pair. Go to WAIT_LOW.
  - IDLE, write_ready=1, level==0: no write. underrun_cnt increments (saturating). Go to WAIT_LOW.
  - IDLE, write_ready=0: stay.
  - WAIT_LOW: write=0. Stay while write_ready=1; on write_ready=0, go to IDLE.
- Consequences of the FSM:
  - At most one write per ready assertion.
  - A sample arriving during WAIT_LOW waits for the next ready window.
  - An underrun is counted once per window.
- writedata_* hold their last value between writes. write latency from a qualifying IDLE cycle is 1 clock.
- in_valid and the pop may coincide in any state. Push and pop are independent except through the full rule above.

Test Plan:
- Reset, then push L=0x1234, R=0xEDCB, att=0; raise write_ready at cycle 10 → write=1 only at cycle 11, writedata_left=0x123400, writedata_right=0xEDCB00, level 1→0.
- att=2: push L=0x8000, R=0x7FFF → written data 0xE00000 and 0x1FFF00.
- DEPTH=4, write_ready=0: push 6 distinct pairs → level=4, overrun_cnt=2; later reads return the first four pairs in order.
- FIFO holds 3 pairs, write_ready held high 20 cycles → exactly one write. Drop and re-raise ready twice → the remaining two pairs are written in order, one per window.
- Empty FIFO, write_ready pulsed high 300 separate times → no write strobe ever; underrun_cnt reaches 255 and holds.
- Full FIFO with in_valid and a pop in the same cycle → level stays 4, overrun_cnt unchanged. Then drive rst=0 during WAIT_LOW → all outputs 0 within the same cycle; after release, the FSM is IDLE and level=0.
